lockstep_req_aligner: RTL and testbench

//  Front stage of the lockstep memory path: between the NB_CORES core data ports and lockstep_unit.

---
 rtl/lockstep_req_aligner_pkg.sv | 21 ++
 rtl/lockstep_req_aligner_if.sv | 24 ++
 rtl/lockstep_req_aligner_addr_cmp.sv | 25 ++
 rtl/lockstep_req_aligner.sv | 171 +++++++++++++++++
 tb/tb_lockstep_req_aligner.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lockstep_req_aligner_pkg.sv
// Shared types for the lockstep request aligner: FSM states, fault cause
// encodings and the width of the optional fault counter.
package lockstep_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SKEW     = 2'd1,
        ISSUE    = 2'd2,
        DEGRADED = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        SKEW_TIMEOUT = 2'b01,
        MIXED_WEN    = 2'b10,
        WR_CONFLICT  = 2'b11
    } cause_e;

    localparam int FAULT_CNT_W = 16;

endpackage

// File: rtl/lockstep_req_aligner_if.sv
// Core-side request bus of the aligner. The slave modport is the aligner
// itself; the master side is the cores plus lockstep_unit (grants, gated
// requests and the read-broadcast qualifier).
interface lockstep_req_aligner_if #(
    parameter int NB_CORES   = 8,
    parameter int ADDR_WIDTH = 32
);
    logic [NB_CORES-1:0]                 req_i;
    logic [NB_CORES-1:0][ADDR_WIDTH-1:0] add_i;
    logic [NB_CORES-1:0]                 wen_i;
    logic [NB_CORES-1:0]                 gnt_i;
    logic [NB_CORES-1:0]                 req_o;
    logic                                same_address_o;

    modport slave (
        input  req_i, add_i, wen_i, gnt_i,
        output req_o, same_address_o
    );

    modport master (
        output req_i, add_i, wen_i, gnt_i,
        input  req_o, same_address_o
    );
endinterface

// File: rtl/lockstep_req_aligner_addr_cmp.sv
// lockstep_addr_cmp: purely combinational comparison of every core against
// core 0. Masks flag cores whose address / direction differ from core 0.
module lockstep_addr_cmp #(
    parameter int NB_CORES   = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic [NB_CORES-1:0][ADDR_WIDTH-1:0] add,
    input  logic [NB_CORES-1:0]                 wen,
    output logic                                addr_eq,
    output logic                                rd_all,
    output logic                                wr_all,
    output logic [NB_CORES-1:0]                 addr_mask,
    output logic [NB_CORES-1:0]                 wen_mask
);

    for (genvar i = 0; i < NB_CORES; i++) begin : g_core
        assign addr_mask[i] = (add[i] != add[0]);
        assign wen_mask[i]  = (wen[i] != wen[0]);
    end

    assign addr_eq = ~|addr_mask;
    assign rd_all  = &wen;
    assign wr_all  = ~|wen;

endmodule

// File: rtl/lockstep_req_aligner.sv
// lockstep_req_aligner: holds core requests until the whole group is present,
// releases them together, flags skew timeouts / mixed direction / same-address
// writes and then falls back to transparent pass-through until cleared.
// Optional: define LOCKSTEP_FAULT_CNT_EN to add fault_cnt_o, a saturating count
// of entries into the degraded state.
module lockstep_req_aligner
    import lockstep_pkg::*;
#(
    parameter int NB_CORES   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int SKEW_MAX   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   lockstep_mode_i,
    input  logic                   clear_i,
    lockstep_req_aligner_if.slave  bus,
    output logic                   fault_o,
    output logic [1:0]             fault_cause_o,
    output logic [NB_CORES-1:0]    fault_mask_o
`ifdef LOCKSTEP_FAULT_CNT_EN
    ,
    output logic [FAULT_CNT_W-1:0] fault_cnt_o
`endif
);

    localparam int CNT_W = $clog2(SKEW_MAX + 1);
    localparam logic [CNT_W-1:0] SKEW_LIM = CNT_W'(SKEW_MAX);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     skew_cnt_q, skew_cnt_d;
    logic                 fault_q;
    cause_e               cause_q, cause_d;
    logic [NB_CORES-1:0]  mask_q, mask_d;
    logic                 enter_deg;
    logic [NB_CORES-1:0]  req_gated;
    logic                 same_addr;

    logic                 addr_eq, rd_all, wr_all;
    logic [NB_CORES-1:0]  addr_mask, wen_mask;
    logic                 all_req, any_req, rel_ok, mixed, clear_ok;

    lockstep_addr_cmp #(
        .NB_CORES   (NB_CORES),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_cmp (
        .add       (bus.add_i),
        .wen       (bus.wen_i),
        .addr_eq   (addr_eq),
        .rd_all    (rd_all),
        .wr_all    (wr_all),
        .addr_mask (addr_mask),
        .wen_mask  (wen_mask)
    );

    assign all_req  = &bus.req_i;
    assign any_req  = |bus.req_i;
    // Distinct-address writes are safe to release; same-address writes would collide.
    assign rel_ok   = all_req & (rd_all | (wr_all & ~addr_eq));
    assign mixed    = ~rd_all & ~wr_all;
    assign clear_ok = clear_i & ~any_req;

    // Next state, request gating and fault detection.
    always_comb begin
        state_d    = state_q;
        skew_cnt_d = skew_cnt_q;
        req_gated  = '0;
        same_addr  = 1'b0;
        enter_deg  = 1'b0;
        cause_d    = CAUSE_NONE;
        mask_d     = '0;
        if (!lockstep_mode_i) begin
            req_gated  = bus.req_i;
            state_d    = IDLE;
            skew_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE, SKEW: begin
                    if (all_req) begin
                        // A complete group beats a timeout landing in the same cycle.
                        skew_cnt_d = '0;
                        if (rel_ok) begin
                            req_gated = bus.req_i;
                            same_addr = rd_all & addr_eq;
                            state_d   = ISSUE;
                        end else begin
                            enter_deg = 1'b1;
                            state_d   = DEGRADED;
                            cause_d   = mixed ? MIXED_WEN : WR_CONFLICT;
                            mask_d    = mixed ? wen_mask : addr_mask;
                        end
                    end else if (state_q == IDLE) begin
                        if (any_req) begin
                            skew_cnt_d = CNT_W'(1);
                            state_d    = SKEW;
                        end
                    end else if (skew_cnt_q == SKEW_LIM) begin
                        skew_cnt_d = '0;
                        enter_deg  = 1'b1;
                        state_d    = DEGRADED;
                        cause_d    = SKEW_TIMEOUT;
                        mask_d     = ~bus.req_i;
                    end else begin
                        skew_cnt_d = skew_cnt_q + CNT_W'(1);
                    end
                end
                ISSUE: begin
                    req_gated = bus.req_i;
                    same_addr = rd_all & addr_eq & all_req;
                    if (|bus.gnt_i) state_d = IDLE;
                end
                default: begin
                    req_gated = bus.req_i;
                    if (clear_ok) state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs to lockstep_unit go quiet the moment reset is asserted.
    assign bus.req_o          = rst_ni ? req_gated : '0;
    assign bus.same_address_o = rst_ni & same_addr;

    // FSM state and skew counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            skew_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            skew_cnt_q <= skew_cnt_d;
        end
    end

    // Sticky fault capture; only an idle clear request wipes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            mask_q  <= '0;
        end else if (enter_deg) begin
            fault_q <= 1'b1;
            cause_q <= cause_d;
            mask_q  <= mask_d;
        end else if (clear_ok) begin
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            mask_q  <= '0;
        end
    end

    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign fault_mask_o  = mask_q;

`ifdef LOCKSTEP_FAULT_CNT_EN
    logic [FAULT_CNT_W-1:0] fault_cnt_q;

    // Saturating count of degraded entries; survives clear_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_cnt_q <= '0;
        end else if (enter_deg && (fault_cnt_q != '1)) begin
            fault_cnt_q <= fault_cnt_q + FAULT_CNT_W'(1);
        end
    end

    assign fault_cnt_o = fault_cnt_q;
`endif

endmodule

// File: tb/tb_lockstep_req_aligner.sv
// Scenario bench for lockstep_req_aligner: each task walks a stimulus table,
// pushes the expected outputs per step and pops them once the DUT has settled.
module tb_lockstep_req_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b1;
    logic        clr = 1'b0;
    logic        fault;
    logic [1:0]  cause;
    logic [7:0]  fmask;
`ifdef LOCKSTEP_FAULT_CNT_EN
    logic [15:0] fcnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [19:0] exp_q[$];

    typedef struct packed {
        logic [7:0]  req;
        logic [7:0]  wen;
        logic [7:0]  gnt;
        logic        mode;
        logic        clr;
        logic [19:0] exp;
    } row_t;

    lockstep_req_aligner_if #(.NB_CORES(8), .ADDR_WIDTH(32)) bus ();

    lockstep_req_aligner #(.NB_CORES(8), .ADDR_WIDTH(32), .SKEW_MAX(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .lockstep_mode_i (mode),
        .clear_i         (clr),
        .bus             (bus),
        .fault_o         (fault),
        .fault_cause_o   (cause),
        .fault_mask_o    (fmask)
`ifdef LOCKSTEP_FAULT_CNT_EN
        ,
        .fault_cnt_o     (fcnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected-output word: {req_o, same_address_o, fault_o, cause, mask}.
    function automatic logic [19:0] ev(logic [7:0] rq, logic sa, logic f,
                                       logic [1:0] c, logic [7:0] m);
        return {rq, sa, f, c, m};
    endfunction

    function automatic row_t r(logic [7:0] rq, logic [7:0] wn, logic [7:0] gn,
                               logic md, logic cl, logic [19:0] e);
        return '{req: rq, wen: wn, gnt: gn, mode: md, clr: cl, exp: e};
    endfunction

    function automatic logic [19:0] outs();
        return {bus.req_o, bus.same_address_o, fault, cause, fmask};
    endfunction

    task automatic set_addr(input logic [31:0] base, input logic [31:0] stride);
        for (int i = 0; i < 8; i++) bus.add_i[i] = base + stride * i;
    endtask

    // Drive one cycle's inputs away from the clock edge and let them settle.
    task automatic apply(input row_t t);
        @(negedge clk);
        bus.req_i = t.req;
        bus.wen_i = t.wen;
        bus.gnt_i = t.gnt;
        mode      = t.mode;
        clr       = t.clr;
        #2;
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        exp_q.push_back(ev(8'h00, 1'b0, 1'b0, 2'b00, 8'h00));
        #1;
        obs = outs();
        total++;
        if (obs !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL reset: got %05h want 00000", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aligned_read();
        row_t t[8];
        logic [19:0] obs, e;
        set_addr(32'h1000, 0);
        t = '{r(8'hFF, 8'hFF, 8'h00, 1, 0, ev(8'hFF, 1, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'hFF, 8'h00, 1, 0, ev(8'hFF, 1, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'hFF, 8'hFF, 1, 0, ev(8'hFF, 1, 0, 2'b00, 8'h00)),
              r(8'h00, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h0F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'hFF, 8'h00, 1, 0, ev(8'hFF, 1, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'hFF, 8'hFF, 1, 0, ev(8'hFF, 1, 0, 2'b00, 8'h00)),
              r(8'h00, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00))};
        foreach (t[i]) begin
            exp_q.push_back(t[i].exp);
            apply(t[i]);
            obs = outs();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL aligned_read step %0d: got %05h want %05h", i, obs, e);
            end
        end
    endtask

    task automatic test_skew_release();
        row_t t[5];
        logic [19:0] obs, e;
        set_addr(32'h3000, 4);
        t = '{r(8'h0F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h0F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'hFF, 8'h00, 1, 0, ev(8'hFF, 0, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'hFF, 8'hFF, 1, 0, ev(8'hFF, 0, 0, 2'b00, 8'h00)),
              r(8'h00, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00))};
        foreach (t[i]) begin
            exp_q.push_back(t[i].exp);
            apply(t[i]);
            obs = outs();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL skew_release step %0d: got %05h want %05h", i, obs, e);
            end
        end
    endtask

    // Last core arrives exactly on the timeout cycle: the group still goes out.
    task automatic test_skew_boundary();
        row_t t[7];
        logic [19:0] obs, e;
        set_addr(32'h3000, 4);
        t = '{r(8'h7F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h7F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h7F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h7F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'hFF, 8'h00, 1, 0, ev(8'hFF, 0, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'hFF, 8'hFF, 1, 0, ev(8'hFF, 0, 0, 2'b00, 8'h00)),
              r(8'h00, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00))};
        foreach (t[i]) begin
            exp_q.push_back(t[i].exp);
            apply(t[i]);
            obs = outs();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL skew_boundary step %0d: got %05h want %05h", i, obs, e);
            end
        end
    endtask

    task automatic test_skew_timeout();
        row_t t[10];
        logic [19:0] obs, e;
        set_addr(32'h3000, 4);
        t = '{r(8'h7F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h7F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h7F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h7F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h7F, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h7F, 8'hFF, 8'h00, 1, 0, ev(8'h7F, 0, 1, 2'b01, 8'h80)),
              r(8'h7F, 8'hFF, 8'h00, 1, 1, ev(8'h7F, 0, 1, 2'b01, 8'h80)),
              r(8'h00, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 1, 2'b01, 8'h80)),
              r(8'h00, 8'hFF, 8'h00, 1, 1, ev(8'h00, 0, 1, 2'b01, 8'h80)),
              r(8'h00, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00))};
        foreach (t[i]) begin
            exp_q.push_back(t[i].exp);
            apply(t[i]);
            obs = outs();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL skew_timeout step %0d: got %05h want %05h", i, obs, e);
            end
        end
    endtask

    task automatic test_mixed_wen();
        row_t t[6];
        logic [19:0] obs, e;
        set_addr(32'h1000, 0);
        t = '{r(8'hFF, 8'hFB, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'hFB, 8'h00, 1, 0, ev(8'hFF, 0, 1, 2'b10, 8'h04)),
              r(8'h00, 8'hFB, 8'h00, 1, 1, ev(8'h00, 0, 1, 2'b10, 8'h04)),
              r(8'h00, 8'hFB, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h01, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h00, 8'hFF, 8'h00, 0, 0, ev(8'h00, 0, 0, 2'b00, 8'h00))};
        foreach (t[i]) begin
            exp_q.push_back(t[i].exp);
            apply(t[i]);
            obs = outs();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL mixed_wen step %0d: got %05h want %05h", i, obs, e);
            end
        end
    endtask

    task automatic test_wr_conflict();
        row_t t[4];
        logic [19:0] obs, e;
        set_addr(32'h2000, 0);
        t = '{r(8'hFF, 8'h00, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'h00, 8'h00, 1, 0, ev(8'hFF, 0, 1, 2'b11, 8'h00)),
              r(8'h00, 8'h00, 8'h00, 1, 1, ev(8'h00, 0, 1, 2'b11, 8'h00)),
              r(8'h00, 8'h00, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00))};
        foreach (t[i]) begin
            exp_q.push_back(t[i].exp);
            apply(t[i]);
            obs = outs();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL wr_conflict step %0d: got %05h want %05h", i, obs, e);
            end
        end
`ifdef LOCKSTEP_FAULT_CNT_EN
        total++;
        if (fcnt !== 16'd3) begin
            bad++;
            $display("FAIL fault_cnt: got %0d want 3", fcnt);
        end
`endif
    endtask

    task automatic test_write_release();
        row_t t[3];
        logic [19:0] obs, e;
        set_addr(32'h4000, 8);
        t = '{r(8'hFF, 8'h00, 8'h00, 1, 0, ev(8'hFF, 0, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'h00, 8'hFF, 1, 0, ev(8'hFF, 0, 0, 2'b00, 8'h00)),
              r(8'h00, 8'h00, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00))};
        foreach (t[i]) begin
            exp_q.push_back(t[i].exp);
            apply(t[i]);
            obs = outs();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL write_release step %0d: got %05h want %05h", i, obs, e);
            end
        end
    endtask

    task automatic test_mode_drop();
        row_t t[3];
        logic [19:0] obs, e;
        set_addr(32'h1000, 0);
        t = '{r(8'h03, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00)),
              r(8'h03, 8'hFF, 8'h00, 0, 0, ev(8'h03, 0, 0, 2'b00, 8'h00)),
              r(8'h00, 8'hFF, 8'h00, 1, 0, ev(8'h00, 0, 0, 2'b00, 8'h00))};
        foreach (t[i]) begin
            exp_q.push_back(t[i].exp);
            apply(t[i]);
            obs = outs();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL mode_drop step %0d: got %05h want %05h", i, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        row_t t[2];
        logic [19:0] obs, e;
        set_addr(32'h1000, 0);
        t = '{r(8'hFF, 8'hFF, 8'h00, 1, 0, ev(8'hFF, 1, 0, 2'b00, 8'h00)),
              r(8'hFF, 8'hFF, 8'h00, 1, 0, ev(8'hFF, 1, 0, 2'b00, 8'h00))};
        foreach (t[i]) begin
            exp_q.push_back(t[i].exp);
            apply(t[i]);
            obs = outs();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL async_reset step %0d: got %05h want %05h", i, obs, e);
            end
        end
        // Mid-cycle reset while ISSUE is still holding the group.
        exp_q.push_back(ev(8'h00, 0, 0, 2'b00, 8'h00));
        rst_n = 1'b0;
        #1;
        obs = outs();
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL async_reset in_reset: got %05h want %05h", obs, e);
        end
`ifdef LOCKSTEP_FAULT_CNT_EN
        total++;
        if (fcnt !== 16'd0) begin
            bad++;
            $display("FAIL fault_cnt_reset: got %0d want 0", fcnt);
        end
`endif
        @(negedge clk);
        bus.req_i = '0;
        rst_n = 1'b1;
        exp_q.push_back(ev(8'h00, 0, 0, 2'b00, 8'h00));
        apply(r(8'h01, 8'hFF, 8'h00, 1, 0, 20'h0));
        obs = outs();
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL async_reset after: got %05h want %05h", obs, e);
        end
    endtask

    initial begin
        bus.req_i = '0;
        bus.wen_i = '1;
        bus.gnt_i = '0;
        set_addr(32'h0, 0);
        test_reset();
        test_aligned_read();
        test_skew_release();
        test_skew_boundary();
        test_skew_timeout();
        test_mixed_wen();
        test_wr_conflict();
        test_write_release();
        test_mode_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
